// File: rtl/pipe_ctrl_v2.sv
// pipe_ctrl_v2 - pipeline hazard / exception / idle controller.
//
// Decides stall (pause) and kill (flush) for every pipeline stage. It also
// arbitrates the exceptions, interrupts, ertn and idle events that the MEM
// stage presents, and produces the front-end redirect.
//
// Ports
//   clk, rst_n          single clock, asynchronous active-low reset
//   pause_req           per-stage stall request (bit 0 = PC, top bit = WB)
//   mem_valid, pc       MEM-stage instruction valid and its PC
//   exception_addr_i    bad address passed through to exception_addr_o
//   is_exception_i      per-source exception flags
//   exception_cause_i   packed causes, source k at [k*CAUSE_W +: CAUSE_W]
//   is_ertn, is_idle    MEM-stage ertn / idle instruction
//   eentry, era, ecfg_lie, estat_is, crmd_ie   architectural CSR values
//   wb_csr_*            CSR write in WB, bypassed onto the CSR values
//   pause, flush        per-stage stall / kill
//   is_exception_o, exception_cause_o, exception_pc_o, exception_addr_o
//   redirect_valid, redirect_pc                front-end redirect
//   is_interrupt_o      pending-and-enabled interrupt line present
//   idle_o              core parked in IDLE
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_RUN   | normal issue; events taken from MEM, pause follows pause_req
// ST_FLUSH | extra flush-hold cycles after a redirect (FLUSH_CYCLES > 1)
// ST_IDLE  | idle instruction retired; everything below WB paused
module pipe_ctrl_v2 #(
    parameter int                   STAGES       = 6,
    parameter int                   EXC_SRC      = 5,
    parameter int                   CAUSE_W      = 7,
    parameter int                   INT_W        = 12,
    parameter int                   FLUSH_CYCLES = 1,
    parameter logic [31:0]          RESET_PC     = 32'h1C000000,
    parameter logic [CAUSE_W-1:0]   CAUSE_NOP    = 7'h7F,
    parameter logic [CAUSE_W-1:0]   CAUSE_INT    = 7'h00
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [STAGES-1:0]           pause_req,
    input  logic                        mem_valid,
    input  logic [31:0]                 pc,
    input  logic [31:0]                 exception_addr_i,
    input  logic [EXC_SRC-1:0]          is_exception_i,
    input  logic [EXC_SRC*CAUSE_W-1:0]  exception_cause_i,
    input  logic                        is_ertn,
    input  logic                        is_idle,
    input  logic [31:0]                 eentry,
    input  logic [31:0]                 era,
    input  logic [INT_W-1:0]            ecfg_lie,
    input  logic [INT_W-1:0]            estat_is,
    input  logic                        crmd_ie,
    input  logic                        wb_csr_we,
    input  logic [13:0]                 wb_csr_waddr,
    input  logic [31:0]                 wb_csr_wdata,
    output logic [STAGES-1:0]           pause,
    output logic [STAGES-1:0]           flush,
    output logic                        is_exception_o,
    output logic [CAUSE_W-1:0]          exception_cause_o,
    output logic [31:0]                 exception_pc_o,
    output logic [31:0]                 exception_addr_o,
    output logic                        redirect_valid,
    output logic [31:0]                 redirect_pc,
    output logic                        is_interrupt_o,
    output logic                        idle_o
);

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) + 1 : 1;

    // Every stage except WB; WB always retires.
    localparam logic [STAGES-1:0] BELOW_WB = {1'b0, {(STAGES-1){1'b1}}};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_IDLE  = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               int_pend_q;

    // ------------------------------------------------------------------
    // CSR bypass from WB
    // ------------------------------------------------------------------
    logic [31:0]      era_cur;
    logic [31:0]      eentry_cur;
    logic [INT_W-1:0] lie_cur;
    logic [INT_W-1:0] is_cur;
    logic             ie_cur;
    logic [INT_W-1:0] int_vec;
    logic [11:0]      wb_int_bits;

    // Interrupt bit 10 is reserved in the write data, hence the gap.
    assign wb_int_bits = {wb_csr_wdata[12:11], wb_csr_wdata[9:0]};

    assign era_cur    = (wb_csr_we && wb_csr_waddr == CSR_ERA)    ? wb_csr_wdata : era;
    assign eentry_cur = (wb_csr_we && wb_csr_waddr == CSR_EENTRY) ? wb_csr_wdata : eentry;
    assign lie_cur    = (wb_csr_we && wb_csr_waddr == CSR_ECFG)   ? INT_W'(wb_int_bits) : ecfg_lie;
    assign is_cur     = (wb_csr_we && wb_csr_waddr == CSR_ESTAT)  ? INT_W'(wb_int_bits) : estat_is;
    assign ie_cur     = (wb_csr_we && wb_csr_waddr == CSR_CRMD)   ? wb_csr_wdata[2] : crmd_ie;

    assign int_vec        = lie_cur & is_cur;
    assign is_interrupt_o = (int_vec != '0);

    assign exception_pc_o   = pc;
    assign exception_addr_o = exception_addr_i;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    logic [CAUSE_W-1:0] exc_cause_sel;
    logic               run_valid;
    logic               int_take;
    logic               exc_raw;
    logic               exc_take;
    logic               ertn_take;
    logic               idle_take;
    logic               redirect;
    logic [STAGES-1:0]  pause_run;

    // Ascending scan: the highest-index active source wins.
    always_comb begin
        exc_cause_sel = CAUSE_NOP;
        for (int k = 0; k < EXC_SRC; k++) begin
            if (is_exception_i[k]) begin
                exc_cause_sel = exception_cause_i[k*CAUSE_W +: CAUSE_W];
            end
        end
    end

    assign run_valid = (state == ST_RUN) && mem_valid;
    assign int_take  = run_valid && int_pend_q && ie_cur;
    assign exc_raw   = run_valid && (pc != RESET_PC) && (is_exception_i != '0);
    assign exc_take  = exc_raw && !int_take;
    assign ertn_take = run_valid && is_ertn && !int_take && !exc_raw;
    assign idle_take = run_valid && is_idle && !int_take && !exc_raw && !is_ertn;
    assign redirect  = int_take || exc_take || ertn_take;

    // Stall everything at and below the deepest requesting stage so that
    // younger instructions never overrun a stalled one.
    always_comb begin
        pause_run = '0;
        for (int i = 0; i < STAGES - 1; i++) begin
            if (pause_req[i]) begin
                pause_run = BELOW_WB >> (STAGES - 2 - i);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            cnt        <= '0;
            int_pend_q <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            int_pend_q <= (int_vec != '0);
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_RUN: begin
                if (redirect && FLUSH_CYCLES > 1) begin
                    state_nx = ST_FLUSH;
                    cnt_nx   = CNT_W'(FLUSH_CYCLES - 1);
                end else if (idle_take) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                cnt_nx = cnt - 1'b1;
                if (cnt <= CNT_W'(1)) begin
                    state_nx = ST_RUN;
                    cnt_nx   = '0;
                end
            end
            ST_IDLE: begin
                // Wake on any pending line, even with interrupts disabled.
                if (int_vec != '0) begin
                    state_nx = ST_RUN;
                end
            end
            default: begin
                state_nx = ST_RUN;
                cnt_nx   = '0;
            end
        endcase
    end

    // Outputs are gated by rst_n so that they drop the moment reset is
    // asserted, regardless of what the inputs are doing.
    always_comb begin
        pause             = '0;
        flush             = '0;
        is_exception_o    = 1'b0;
        exception_cause_o = CAUSE_NOP;
        redirect_valid    = 1'b0;
        redirect_pc       = eentry_cur;
        idle_o            = 1'b0;
        if (rst_n) begin
            case (state)
                ST_RUN: begin
                    if (int_take) begin
                        is_exception_o    = 1'b1;
                        exception_cause_o = CAUSE_INT;
                        redirect_valid    = 1'b1;
                    end else if (exc_take) begin
                        is_exception_o    = 1'b1;
                        exception_cause_o = exc_cause_sel;
                        redirect_valid    = 1'b1;
                    end else if (ertn_take) begin
                        redirect_valid    = 1'b1;
                        redirect_pc       = era_cur;
                    end
                    if (redirect) begin
                        flush = BELOW_WB;
                    end else begin
                        pause = pause_run;
                    end
                end
                ST_FLUSH: begin
                    flush = BELOW_WB;
                end
                ST_IDLE: begin
                    idle_o = 1'b1;
                    pause  = BELOW_WB;
                end
                default: begin
                    pause = '0;
                end
            endcase
        end
    end

endmodule

// File: doc/pipe_ctrl_v2.md
PIPE_CTRL_V2 -- requirements
Module: pipe_ctrl_v2

Interface
REQ-001 SHALL provide parameters: STAGES, default 6, number of pipeline stages (bit 0 = PC, bit STAGES-1 = WB); EXC_SRC, default 5, number of exception sources; CAUSE_W, default 7, cause width; INT_W, default 12, interrupt lines; FLUSH_CYCLES, default 1, flush hold length (>=1); RESET_PC, default 32'h1C000000, PC whose exceptions are suppressed; CAUSE_NOP, default 7'h7F, idle cause; CAUSE_INT, default 7'h00, interrupt cause.
REQ-002 SHALL have ports: clk in 1, single clock; rst_n in 1, asynchronous active-low reset.
REQ-003 SHALL have ports: pause_req in STAGES, per-stage stall request; mem_valid in 1, MEM-stage instruction valid; pc in 32, MEM PC; exception_addr_i in 32, bad address.
REQ-004 SHALL have ports: is_exception_i in EXC_SRC, source flags; exception_cause_i in EXC_SRC*CAUSE_W, source k at [k*CAUSE_W +: CAUSE_W]; is_ertn in 1; is_idle in 1.
REQ-005 SHALL have ports: eentry in 32; era in 32; ecfg_lie in INT_W; estat_is in INT_W; crmd_ie in 1; wb_csr_we in 1; wb_csr_waddr in 14; wb_csr_wdata in 32.
REQ-006 SHALL have ports: pause out STAGES; flush out STAGES; is_exception_o out 1; exception_cause_o out CAUSE_W; exception_pc_o out 32; exception_addr_o out 32; redirect_valid out 1; redirect_pc out 32; is_interrupt_o out 1; idle_o out 1.

Function
REQ-007 SHALL form current CSR values by WB bypass: wb_csr_we with matching CSR_ERA/CSR_EENTRY/CSR_ECFG/CSR_ESTAT/CSR_CRMD address overrides era/eentry/lie/is/ie; LIE/IS take wdata bits {12:11,9:0}; IE takes wdata[2].
REQ-008 SHALL compute int_vec = lie_cur & is_cur; is_interrupt_o = (int_vec != 0), combinational.
REQ-009 SHALL register int_pend_q <= (int_vec != 0) every cycle; interrupt taken (int_take) when state RUN, mem_valid, int_pend_q, ie_cur.
REQ-010 SHALL raise sync exception (exc_take) when state RUN, mem_valid, pc != RESET_PC, is_exception_i != 0; cause from highest-index set source.
REQ-011 SHALL prioritise events in RUN: int_take > exc_take > is_ertn > is_idle; lower ones ignored that cycle.
REQ-012 SHALL on int_take or exc_take, in same cycle: is_exception_o=1, exception_cause_o=CAUSE_INT or selected cause, redirect_valid=1, redirect_pc=eentry_cur.
REQ-013 SHALL on ertn (mem_valid, no higher event): redirect_valid=1, redirect_pc=era_cur, is_exception_o=0.
REQ-014 SHALL pass exception_pc_o=pc and exception_addr_o=exception_addr_i unconditionally.
REQ-015 SHALL default is_exception_o=0, exception_cause_o=CAUSE_NOP, redirect_valid=0, redirect_pc=eentry_cur.
REQ-016 SHALL implement FSM RUN/FLUSH/IDLE, state and hold counter registered on clk.
REQ-017 SHALL in RUN on any redirect: flush = ones on bits STAGES-2..0 (WB never flushed); go FLUSH if FLUSH_CYCLES>1 with counter loaded FLUSH_CYCLES-1, else stay RUN.
REQ-018 SHALL in FLUSH: hold same flush vector, pause=0, redirect_valid=0, events ignored; decrement counter; return RUN after counter reaches 1.
REQ-019 SHALL in RUN on is_idle (mem_valid, no higher event): go IDLE next cycle; no flush.
REQ-020 SHALL in IDLE: idle_o=1, pause = ones on bits STAGES-2..0; exit to RUN the cycle after int_vec != 0, regardless of ie_cur.
REQ-021 SHALL in RUN without redirect: pause = ones on bits i..0 for highest i < STAGES-1 with pause_req[i]=1, else 0; pause_req[STAGES-1] ignored.
REQ-022 SHALL force pause=0 in any cycle where flush != 0.

Reset
REQ-023 SHALL on rst_n=0, asynchronously: state RUN, counter 0, int_pend_q 0; pause=0, flush=0, idle_o=0, is_exception_o=0, redirect_valid=0, exception_cause_o=CAUSE_NOP.
REQ-024 SHALL abort FLUSH/IDLE on reset mid-operation with no further flush or pause after release.

Verification
REQ-025 SHALL verify: pause_req=6'b001000 and 6'b000100 together -> pause=6'b001111, flush=0.
REQ-026 SHALL verify: is_exception_i=5'b00110, cause slots 1=7'h0B, 2=7'h0A, pc=32'h1C000010, mem_valid=1 -> is_exception_o=1, cause 7'h0A, redirect_pc=eentry, flush=6'b011111.
REQ-027 SHALL verify: same exception with pc=32'h1C000000 -> is_exception_o=0, flush=0, cause 7'h7F.
REQ-028 SHALL verify: FLUSH_CYCLES=3, ertn with era=32'h1C000100 and same-cycle WB write to ERA 32'h1C000200 -> redirect_pc=32'h1C000200, flush held 3 cycles, pause_req ignored.
REQ-029 SHALL verify: idle, then estat_is[11]=1, lie[11]=1, ie=1 -> IDLE pause=6'b011111 until wake; RUN next cycle; int_take following cycle with cause 7'h00.
REQ-030 SHALL verify: rst_n low during IDLE -> pause=0, idle_o=0 immediately, without clock edge.
